// File: rtl/spi_byte_engine_pkg.sv
// Shared definitions for the SPI mode-0 byte engine: byte geometry and FSM
// state encoding used by the engine and its half-period divider.
package spi_byte_engine_pkg;

  localparam int SPI_BYTE_BITS = 8;
  localparam int SPI_BIT_W     = $clog2(SPI_BYTE_BITS);
  localparam int SPI_MSB       = SPI_BYTE_BITS - 1;

  typedef enum logic [1:0] {
    SPI_ST_IDLE = 2'd0,
    SPI_ST_LO   = 2'd1,
    SPI_ST_HI   = 2'd2,
    SPI_ST_DONE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_byte_engine_if.sv
// Bundle between the Wishbone SPI peripheral (master side, also modelling the
// SPI slave pin) and the byte engine (slave side, drives SCLK/MOSI).
interface spi_byte_engine_if;
  import spi_byte_engine_pkg::*;

  logic [SPI_BYTE_BITS-1:0] tx_data;
  logic                     tx_start;
  logic [SPI_BYTE_BITS-1:0] rx_data;
  logic                     busy;
  logic                     spi_miso;
  logic                     spi_mosi;
  logic                     spi_clk;

  modport master (
    output tx_data,
    output tx_start,
    output spi_miso,
    input  rx_data,
    input  busy,
    input  spi_mosi,
    input  spi_clk
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    input  spi_miso,
    output rx_data,
    output busy,
    output spi_mosi,
    output spi_clk
  );

endinterface

// File: rtl/spi_byte_engine_tick_gen.sv
// SCLK half-period divider: pulses O_tick once every CLK_HALF clocks while
// I_run is high; the count restarts from zero whenever I_run drops.
module spi_byte_engine_tick_gen #(
  parameter int CLK_HALF = 1
) (
  input  logic I_clk,
  input  logic I_reset_n,
  input  logic I_run,
  output logic O_tick
);

  generate
    if (CLK_HALF < 1) begin : g_bad_clk_half
      $error("spi_byte_engine_tick_gen: CLK_HALF must be >= 1");
    end
  endgenerate

  localparam int DIV_W = (CLK_HALF < 1) ? 1 : $clog2(CLK_HALF + 1);
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_HALF - 1);

  logic [DIV_W-1:0] divcnt_reg;
  logic [DIV_W-1:0] divcnt_next;

  assign O_tick = I_run && (divcnt_reg == DIV_TERM);

  // Wrapping on the tick means the count restarts at every phase change.
  always_comb begin
    divcnt_next = '0;
    if (I_run && !O_tick) begin
      divcnt_next = divcnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      divcnt_reg <= '0;
    end else begin
      divcnt_reg <= divcnt_next;
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte engine, MSB first: shifts one byte out on
// MOSI while sampling one byte in on MISO, with a level start/busy handshake.
module spi_byte_engine
  import spi_byte_engine_pkg::*;
#(
  parameter int CLK_HALF = 1
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  spi_byte_engine_if.slave bus
);

  localparam logic [SPI_BIT_W-1:0] LAST_BIT = SPI_BIT_W'(SPI_BYTE_BITS - 1);

  spi_state_e               state_reg;
  spi_state_e               state_next;
  logic [SPI_BYTE_BITS-1:0] shreg_reg;
  logic [SPI_BYTE_BITS-1:0] shreg_next;
  logic [SPI_BYTE_BITS-1:0] rx_data_reg;
  logic [SPI_BYTE_BITS-1:0] rx_data_next;
  logic [SPI_BIT_W-1:0]     bitcnt_reg;
  logic [SPI_BIT_W-1:0]     bitcnt_next;
  logic                     rxbit_reg;
  logic                     rxbit_next;
  logic                     sclk_reg;
  logic                     sclk_next;
  logic                     busy_reg;
  logic                     busy_next;
  logic                     phase_run;
  logic                     phase_tick;

  assign phase_run = (state_reg == SPI_ST_LO) || (state_reg == SPI_ST_HI);

  spi_byte_engine_tick_gen #(
    .CLK_HALF (CLK_HALF)
  ) u_tick_gen (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_run     (phase_run),
    .O_tick    (phase_tick)
  );

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    rx_data_next = rx_data_reg;
    bitcnt_next  = bitcnt_reg;
    rxbit_next   = rxbit_reg;
    sclk_next    = sclk_reg;
    busy_next    = busy_reg;

    case (state_reg)
      SPI_ST_IDLE: begin
        if (bus.tx_start) begin
          shreg_next  = bus.tx_data;
          busy_next   = 1'b1;
          bitcnt_next = '0;
          state_next  = SPI_ST_LO;
        end
      end

      SPI_ST_LO: begin
        if (phase_tick) begin
          sclk_next  = 1'b1;
          rxbit_next = bus.spi_miso;
          state_next = SPI_ST_HI;
        end
      end

      SPI_ST_HI: begin
        if (phase_tick) begin
          sclk_next = 1'b0;
          if (bitcnt_reg == LAST_BIT) begin
            rx_data_next = {shreg_reg[SPI_MSB-1:0], rxbit_reg};
            state_next   = SPI_ST_DONE;
          end else begin
            shreg_next  = {shreg_reg[SPI_MSB-1:0], rxbit_reg};
            bitcnt_next = bitcnt_reg + SPI_BIT_W'(1);
            state_next  = SPI_ST_LO;
          end
        end
      end

      SPI_ST_DONE: begin
        // A start still held from the finished byte must not retrigger.
        if (!bus.tx_start) begin
          busy_next  = 1'b0;
          state_next = SPI_ST_IDLE;
        end
      end

      default: begin
        state_next = SPI_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_reg   <= SPI_ST_IDLE;
      shreg_reg   <= '0;
      rx_data_reg <= '0;
      bitcnt_reg  <= '0;
      rxbit_reg   <= 1'b0;
      sclk_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      rx_data_reg <= rx_data_next;
      bitcnt_reg  <= bitcnt_next;
      rxbit_reg   <= rxbit_next;
      sclk_reg    <= sclk_next;
      busy_reg    <= busy_next;
    end
  end

  // The shift-register MSB is exactly the bit on the wire: loaded with
  // tx_data[7] at accept and advanced only on SCLK falling edges.
  assign bus.spi_mosi = shreg_reg[SPI_MSB];
  assign bus.spi_clk  = sclk_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.busy     = busy_reg;

  a_sclk_low_when_parked : assert property (
    @(posedge I_clk) disable iff (!I_reset_n)
    ((state_reg == SPI_ST_IDLE) || (state_reg == SPI_ST_DONE)) |-> !sclk_reg
  );

  a_busy_outside_idle : assert property (
    @(posedge I_clk) disable iff (!I_reset_n)
    (state_reg != SPI_ST_IDLE) |-> busy_reg
  );

endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: two instances (CLK_HALF=1 and 3) share stimulus;
// a cycle-count model predicts SCLK/MOSI/busy/rx_data for each on every cycle.
module tb_spi_byte_engine;

  localparam int N_DUT = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  int         miso_mode;   // 0 loopback, 1 tied high, 2 slave byte
  logic [7:0] slave_byte;

  logic       sclk_o   [N_DUT];
  logic       mosi_o   [N_DUT];
  logic       busy_o   [N_DUT];
  logic [7:0] rx_o     [N_DUT];
  logic       miso_val [N_DUT];

  int checks = 0;
  int errors = 0;

  bit         m_active [N_DUT];
  int         m_n      [N_DUT];
  logic [7:0] m_tx     [N_DUT];
  logic [7:0] m_tgt    [N_DUT];
  logic [7:0] m_rx     [N_DUT];
  logic       m_mosi   [N_DUT];

  int         rises     [N_DUT];
  int         busy_cnt  [N_DUT];
  int         rise_t0   [N_DUT];
  int         rise_t1   [N_DUT];
  logic [7:0] rise_bits [N_DUT];
  logic       prev_sclk [N_DUT];
  int         cyc;

  function automatic int ch_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_DUT; gi++) begin : g_dut
      spi_byte_engine_if ifc ();
      assign ifc.tx_data  = tx_data;
      assign ifc.tx_start = tx_start;
      assign ifc.spi_miso = (miso_mode == 0) ? ifc.spi_mosi : miso_val[gi];
      assign sclk_o[gi]   = ifc.spi_clk;
      assign mosi_o[gi]   = ifc.spi_mosi;
      assign busy_o[gi]   = ifc.busy;
      assign rx_o[gi]     = ifc.rx_data;

      spi_byte_engine #(
        .CLK_HALF (gi == 0 ? 1 : 3)
      ) u_dut (
        .I_clk     (clk),
        .I_reset_n (rst_n),
        .bus       (ifc.slave)
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out @cyc %0d", name, cyc);
  endtask

  // Per-cycle reference: outputs follow from cycles elapsed since accept.
  initial begin
    cyc = 0;
    for (int i = 0; i < N_DUT; i++) begin
      m_active[i] = 0; m_n[i] = 0; m_tx[i] = 0; m_tgt[i] = 0; m_rx[i] = 0; m_mosi[i] = 0;
      rises[i] = 0; busy_cnt[i] = 0; rise_t0[i] = 0; rise_t1[i] = 0; rise_bits[i] = 0;
      prev_sclk[i] = 0; miso_val[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N_DUT; i++) begin
        logic e_sclk, e_mosi, e_busy;
        int   ch, p, bidx;
        ch = ch_of(i);
        if (!rst_n) begin
          m_active[i] = 0; m_n[i] = 0; m_rx[i] = 8'h00; m_mosi[i] = 1'b0;
        end
        if (!m_active[i]) begin
          e_sclk = 1'b0; e_busy = 1'b0; e_mosi = m_mosi[i];
        end else if (m_n[i] < 16 * ch) begin
          p      = m_n[i] / ch;
          e_sclk = p[0];
          e_mosi = m_tx[i][7 - p / 2];
          e_busy = 1'b1;
        end else begin
          e_sclk = 1'b0; e_busy = 1'b1; e_mosi = m_tx[i][0];
        end
        check("sclk", i, 32'(sclk_o[i]), 32'(e_sclk));
        check("mosi", i, 32'(mosi_o[i]), 32'(e_mosi));
        check("busy", i, 32'(busy_o[i]), 32'(e_busy));
        check("rx_data", i, 32'(rx_o[i]), 32'(m_rx[i]));

        if (busy_o[i]) busy_cnt[i]++;
        if (sclk_o[i] && !prev_sclk[i]) begin
          rises[i]++;
          rise_bits[i] = {rise_bits[i][6:0], mosi_o[i]};
          if (rises[i] == 1) rise_t0[i] = cyc;
          else if (rises[i] == 2) rise_t1[i] = cyc;
        end
        prev_sclk[i] = sclk_o[i];

        if (rst_n) begin
          if (!m_active[i]) begin
            if (tx_start) begin
              m_active[i] = 1; m_n[i] = 0; m_tx[i] = tx_data;
              m_tgt[i] = (miso_mode == 0) ? tx_data : (miso_mode == 1) ? 8'hFF : slave_byte;
              rises[i] = 0; busy_cnt[i] = 0; rise_bits[i] = 0; rise_t0[i] = 0; rise_t1[i] = 0;
            end
          end else if (m_n[i] < 16 * ch) begin
            m_n[i]++;
            if (m_n[i] == 16 * ch) m_rx[i] = m_tgt[i];
          end else if (!tx_start) begin
            m_active[i] = 0;
            m_mosi[i]   = m_tx[i][0];
          end
        end

        bidx = (m_active[i] && m_n[i] < 16 * ch) ? m_n[i] / (2 * ch) : 0;
        miso_val[i] = (miso_mode == 1) ? 1'b1 : slave_byte[7 - bidx];
      end
    end
  end

  task automatic do_xfer(input logic [7:0] tx, input bit hold);
    int k;
    @(posedge clk); #2;
    tx_data  = tx;
    tx_start = 1'b1;
    k = 0;
    while (!(busy_o[0] && busy_o[1]) && k < 5) begin
      @(posedge clk); #2;
      k++;
    end
    if (k == 5) fail_now("busy_rise");
    if (!hold) tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy_o[0] || busy_o[1]) && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    if (k == 200) fail_now("busy_fall");
  endtask

  task automatic check_rx_both(input string name, input logic [7:0] exp);
    for (int i = 0; i < N_DUT; i++) begin
      check(name, i, 32'(rx_o[i]), 32'(exp));
      check({name, "_rises"}, i, rises[i], 8);
    end
  endtask

  initial begin
    int k;
    logic [7:0] tx, exp;
    rst_n = 1'b0; tx_start = 1'b0; tx_data = 8'h00; miso_mode = 0; slave_byte = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < N_DUT; i++) begin
      check("rst_sclk", i, 32'(sclk_o[i]), 0);
      check("rst_busy", i, 32'(busy_o[i]), 0);
      check("rst_mosi", i, 32'(mosi_o[i]), 0);
      check("rst_rx", i, 32'(rx_o[i]), 32'h00);
    end

    // Abort after 3 SCLK rises: outputs drop immediately, no partial byte.
    miso_mode = 0;
    do_xfer(8'h5A, 1'b0);
    k = 0;
    while (rises[0] < 3 && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    if (k == 20) fail_now("abort_rises");
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check("abort_sclk", i, 32'(sclk_o[i]), 0);
      check("abort_busy", i, 32'(busy_o[i]), 0);
      check("abort_mosi", i, 32'(mosi_o[i]), 0);
      check("abort_rx", i, 32'(rx_o[i]), 32'h00);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    do_xfer(8'h96, 1'b0);
    wait_idle();
    check_rx_both("post_abort_rx", 8'h96);

    // Loopback A5: busy spans 16*CLK_HALF+1 cycles.
    miso_mode = 0;
    do_xfer(8'hA5, 1'b0);
    wait_idle();
    check_rx_both("loop_rx", 8'hA5);
    check("loop_busy_cycles", 0, busy_cnt[0], 17);
    check("loop_busy_cycles", 1, busy_cnt[1], 49);

    // MISO tied high, send 00.
    miso_mode = 1;
    do_xfer(8'h00, 1'b0);
    wait_idle();
    check_rx_both("tied_rx", 8'hFF);
    check("tied_mosi_bits", 0, 32'(rise_bits[0]), 32'h00);
    check("tied_mosi_bits", 1, 32'(rise_bits[1]), 32'h00);
    check("sclk_period", 0, rise_t1[0] - rise_t0[0], 2);
    check("sclk_period", 1, rise_t1[1] - rise_t0[1], 6);

    // Slave returns 3C while C3 goes out.
    miso_mode = 2;
    slave_byte = 8'h3C;
    do_xfer(8'hC3, 1'b0);
    wait_idle();
    check_rx_both("slave_rx", 8'h3C);
    check("slave_mosi_bits", 0, 32'(rise_bits[0]), 32'hC3);
    check("slave_mosi_bits", 1, 32'(rise_bits[1]), 32'hC3);

    // Start held through completion.
    miso_mode = 0;
    do_xfer(8'h81, 1'b1);
    repeat (60) @(posedge clk);
    #2;
    for (int i = 0; i < N_DUT; i++) begin
      check("hold_busy", i, 32'(busy_o[i]), 1);
      check("hold_rises", i, rises[i], 8);
      check("hold_rx", i, 32'(rx_o[i]), 32'h81);
    end
    tx_start = 1'b0;
    @(posedge clk); #2;
    check("release_busy", 0, 32'(busy_o[0]), 0);
    check("release_busy", 1, 32'(busy_o[1]), 0);

    // Re-pulsed start with new data mid-transfer is ignored.
    do_xfer(8'h4E, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    repeat (2) @(posedge clk);
    #2 tx_start = 1'b0;
    wait_idle();
    check_rx_both("repulse_rx", 8'h4E);

    for (int t = 0; t < 16; t++) begin
      miso_mode  = int'($urandom_range(0, 2));
      slave_byte = 8'($urandom);
      tx         = 8'($urandom);
      do_xfer(tx, 1'b0);
      wait_idle();
      exp = (miso_mode == 0) ? tx : (miso_mode == 1) ? 8'hFF : slave_byte;
      $display("xfer %0d: mode %0d tx %02h -> rx %02h / %02h (want %02h)",
               t, miso_mode, tx, rx_o[0], rx_o[1], exp);
      check_rx_both("rand_rx", exp);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (%0d checks, %0d errors)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
